// File: rtl/pipe_redirect_ctrl_pkg.sv
// Shared types for the redirect/hazard controller: FSM states and redirect source tags.
// No logic; 0 cycles; no backpressure.
// Imported by pipe_redirect_ctrl and redirect_hold.
package pipe_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } redir_state_t;

    // Source tag stored with a held redirect; decides whether EX is flushed on issue
    localparam logic REDIR_BR  = 1'b0;
    localparam logic REDIR_JMP = 1'b1;

endpackage

// File: rtl/pipe_redirect_ctrl_redirect_hold.sv
// Single-entry pending redirect (valid, pc, tag) held while data memory is busy.
// Latency: written at the clock edge after set; clear wins over set.
// Backpressure: a set is ignored while the entry is already valid (oldest redirect kept).
module redirect_hold
    import pipe_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            set,
    input  logic [XLEN-1:0] set_pc,
    input  logic            set_tag,
    input  logic            clr,
    output logic            vld,
    output logic [XLEN-1:0] pc,
    output logic            tag
);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld <= 1'b0;
            pc  <= '0;
            tag <= REDIR_BR;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (set && !vld) begin
            vld <= 1'b1;
            pc  <= set_pc;
            tag <= set_tag;
        end
    end

endmodule

// File: rtl/pipe_redirect_ctrl.sv
// Hazard/redirect controller: PC mux select, stage stalls/flushes, squash window.
// Latency: redirect/stall/flush are combinational (0 cycles); squash is registered (+1).
// Backpressure: mem_busy stalls every stage and parks any redirect until it drops.
module pipe_redirect_ctrl
    import pipe_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int XLEN         = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_req,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            ld_use,
    input  logic            mem_busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            stall_mem,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            squash,
    output logic [15:0]     redirect_count
);

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    redir_state_t    state, next_state;
    logic [1:0]      flush_cnt;
    logic            pend_set, pend_clr, pend_vld, pend_tag;
    logic [XLEN-1:0] pend_pc;

    redirect_hold #(.XLEN(XLEN)) u_hold (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .set     (pend_set),
        .set_pc  (br_req ? br_target : jmp_target),
        .set_tag (br_req ? REDIR_BR : REDIR_JMP),
        .clr     (pend_clr),
        .vld     (pend_vld),
        .pc      (pend_pc),
        .tag     (pend_tag)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= RUN;
            flush_cnt      <= 2'd0;
            squash         <= 1'b0;
            redirect_count <= 16'd0;
        end else begin
            state  <= next_state;
            squash <= (next_state == FLUSH);
            if (redirect_valid)
                redirect_count <= redirect_count + 16'd1;
            // Counter loads on entry; frozen while memory holds the pipe
            if (state != FLUSH && next_state == FLUSH)
                flush_cnt <= CNT_INIT;
            else if (state == FLUSH && !mem_busy && flush_cnt != 2'd0)
                flush_cnt <= flush_cnt - 2'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (mem_busy)               next_state = MEM_WAIT;
                else if (br_req || jmp_req) next_state = FLUSH;
            end
            FLUSH: begin
                if (!mem_busy && flush_cnt == 2'd0) next_state = RUN;
            end
            MEM_WAIT: begin
                if (mem_busy)                           next_state = MEM_WAIT;
                else if (pend_vld || br_req || jmp_req) next_state = FLUSH;
                else                                    next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        pend_set       = 1'b0;
        pend_clr       = 1'b0;
        if (i_rst) begin
            if (mem_busy) begin
                {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                pend_set = (state != FLUSH) && (br_req || jmp_req);
            end else if (state == MEM_WAIT && pend_vld) begin
                redirect_valid = 1'b1;
                redirect_pc    = pend_pc;
                flush_id       = 1'b1;
                flush_ex       = (pend_tag == REDIR_BR);
                pend_clr       = 1'b1;
            end else if (state != FLUSH) begin
                // Branch beats jump (younger, wrong path) and load-use (ID gets flushed)
                if (br_req) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = br_target;
                    flush_id       = 1'b1;
                    flush_ex       = 1'b1;
                end else if (jmp_req) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = jmp_target;
                    flush_id       = 1'b1;
                end else if (ld_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Directed bench for pipe_redirect_ctrl; a second instance runs with a 3-cycle squash window.
module tb_pipe_redirect_ctrl;

    logic        i_clk, i_rst;
    logic        br_req, jmp_req, ld_use, mem_busy;
    logic [31:0] br_target, jmp_target;

    logic        rv, sif, sid, sex, smem, fid, fex, sq;
    logic [31:0] rpc;
    logic [15:0] cnt;
    logic        rv3, sif3, sid3, sex3, smem3, fid3, fex3, sq3;
    logic [31:0] rpc3;
    logic [15:0] cnt3;

    int checks = 0;
    int failures = 0;

    pipe_redirect_ctrl #(.FLUSH_CYCLES(1), .XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .br_req(br_req), .br_target(br_target), .jmp_req(jmp_req), .jmp_target(jmp_target),
        .ld_use(ld_use), .mem_busy(mem_busy),
        .redirect_valid(rv), .redirect_pc(rpc),
        .stall_if(sif), .stall_id(sid), .stall_ex(sex), .stall_mem(smem),
        .flush_id(fid), .flush_ex(fex), .squash(sq), .redirect_count(cnt)
    );

    pipe_redirect_ctrl #(.FLUSH_CYCLES(3), .XLEN(32)) dut3 (
        .i_clk(i_clk), .i_rst(i_rst),
        .br_req(br_req), .br_target(br_target), .jmp_req(jmp_req), .jmp_target(jmp_target),
        .ld_use(ld_use), .mem_busy(mem_busy),
        .redirect_valid(rv3), .redirect_pc(rpc3),
        .stall_if(sif3), .stall_id(sid3), .stall_ex(sex3), .stall_mem(smem3),
        .flush_id(fid3), .flush_ex(fex3), .squash(sq3), .redirect_count(cnt3)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; br_req = 0; jmp_req = 0; ld_use = 0; mem_busy = 0;
        br_target = 0; jmp_target = 0;
        #2;
        checks++; if ({rv, sif, sid, sex, smem, fid, fex, sq} !== 8'h00) begin failures++; $display("FAIL reset_outs got=%b exp=00000000", {rv, sif, sid, sex, smem, fid, fex, sq}); end
        checks++; if (rpc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", rpc); end
        checks++; if (cnt !== 16'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
        tick();
        i_rst = 1'b1;
    endtask

    task automatic test_branch();
        br_req = 1; br_target = 32'h40;
        @(negedge i_clk);
        checks++; if (rv !== 1'b1 || rpc !== 32'h40) begin failures++; $display("FAIL br_redirect got=%b/%h exp=1/00000040", rv, rpc); end
        checks++; if ({fid, fex, sif} !== 3'b110) begin failures++; $display("FAIL br_flush got=%b exp=110", {fid, fex, sif}); end
        checks++; if (sq !== 1'b0) begin failures++; $display("FAIL br_squash_early got=%b exp=0", sq); end
        tick();
        br_req = 0;
        @(negedge i_clk);
        checks++; if (sq !== 1'b1 || rv !== 1'b0) begin failures++; $display("FAIL br_squash got=%b/%b exp=1/0", sq, rv); end
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL br_count got=%0d exp=1", cnt); end
        tick();
        @(negedge i_clk);
        checks++; if (sq !== 1'b0) begin failures++; $display("FAIL br_squash_len got=%b exp=0", sq); end
        tick();
    endtask

    task automatic test_br_jmp();
        br_req = 1; br_target = 32'h44; jmp_req = 1; jmp_target = 32'h80;
        @(negedge i_clk);
        checks++; if (rpc !== 32'h44 || fex !== 1'b1) begin failures++; $display("FAIL brjmp_pc got=%h/%b exp=00000044/1", rpc, fex); end
        tick();
        br_req = 0;
        @(negedge i_clk);
        checks++; if (rv !== 1'b0) begin failures++; $display("FAIL brjmp_jump_issued got=%b exp=0", rv); end
        checks++; if (cnt !== 16'd2) begin failures++; $display("FAIL brjmp_count got=%0d exp=2", cnt); end
        tick();
        jmp_req = 0;
    endtask

    task automatic test_ld_use();
        ld_use = 1;
        @(negedge i_clk);
        checks++; if ({sif, sid, sex, smem, fid, fex, rv} !== 7'b1100010) begin failures++; $display("FAIL lduse_ctl got=%b exp=1100010", {sif, sid, sex, smem, fid, fex, rv}); end
        tick();
        ld_use = 0;
        @(negedge i_clk);
        checks++; if ({sif, fex} !== 2'b00) begin failures++; $display("FAIL lduse_release got=%b exp=00", {sif, fex}); end
        tick();
        ld_use = 1; br_req = 1; br_target = 32'h48;
        @(negedge i_clk);
        checks++; if ({rv, sif, sid, fid, fex} !== 5'b10011 || rpc !== 32'h48) begin failures++; $display("FAIL lduse_br got=%b/%h exp=10011/00000048", {rv, sif, sid, fid, fex}, rpc); end
        tick();
        ld_use = 0; br_req = 0;
        tick();
    endtask

    task automatic test_mem_wait();
        mem_busy = 1; br_req = 1; br_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checks++; if ({sif, sid, sex, smem, rv} !== 5'b11110) begin failures++; $display("FAIL memwait_stall%0d got=%b exp=11110", i, {sif, sid, sex, smem, rv}); end
            tick();
            br_target = 32'h200;
        end
        mem_busy = 0;
        @(negedge i_clk);
        checks++; if (rv !== 1'b1 || rpc !== 32'h100) begin failures++; $display("FAIL memwait_issue got=%b/%h exp=1/00000100", rv, rpc); end
        checks++; if ({sif, fid, fex} !== 3'b011) begin failures++; $display("FAIL memwait_flush got=%b exp=011", {sif, fid, fex}); end
        tick();
        br_req = 0;
        @(negedge i_clk);
        checks++; if (cnt !== 16'd4 || sq !== 1'b1) begin failures++; $display("FAIL memwait_count got=%0d/%b exp=4/1", cnt, sq); end
        tick();
    endtask

    task automatic test_flush3();
        i_rst = 0;
        tick();
        i_rst = 1;
        br_req = 1; br_target = 32'h60;
        @(negedge i_clk);
        checks++; if (rv3 !== 1'b1 || rpc3 !== 32'h60) begin failures++; $display("FAIL f3_redirect got=%b/%h exp=1/00000060", rv3, rpc3); end
        tick();
        for (int i = 0; i < 3; i++) begin
            br_req = (i != 1);
            @(negedge i_clk);
            checks++; if (sq3 !== 1'b1 || rv3 !== 1'b0) begin failures++; $display("FAIL f3_window%0d got=%b/%b exp=1/0", i, sq3, rv3); end
            tick();
        end
        br_req = 0;
        @(negedge i_clk);
        checks++; if (sq3 !== 1'b0) begin failures++; $display("FAIL f3_squash_end got=%b exp=0", sq3); end
        checks++; if (cnt3 !== 16'd1) begin failures++; $display("FAIL f3_count got=%0d exp=1", cnt3); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        i_rst = 0;
        tick();
        i_rst = 1;
        mem_busy = 1; jmp_req = 1; jmp_target = 32'h80;
        tick();
        @(negedge i_clk);
        checks++; if (sif !== 1'b1) begin failures++; $display("FAIL rstwait_stall got=%b exp=1", sif); end
        i_rst = 0;
        #1;
        checks++; if ({rv, sif, sid, sex, smem, fid, fex, sq} !== 8'h00 || rpc !== 32'h0) begin failures++; $display("FAIL rstwait_outs got=%b/%h exp=00000000/0", {rv, sif, sid, sex, smem, fid, fex, sq}, rpc); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL rstwait_count got=%0d exp=0", cnt); end
        tick();
        i_rst = 1; mem_busy = 0; jmp_req = 0;
        @(negedge i_clk);
        checks++; if (rv !== 1'b0) begin failures++; $display("FAIL rstwait_stale_redirect got=%b exp=0", rv); end
        tick();
        @(negedge i_clk);
        checks++; if (cnt !== 16'd0 || sq !== 1'b0) begin failures++; $display("FAIL rstwait_after got=%0d/%b exp=0/0", cnt, sq); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_br_jmp();
        test_ld_use();
        test_mem_wait();
        test_flush3();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
